// File: rtl/reg_input_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : register_pkg                                                 |
// | Purpose   : Shared sizing constants and the data word type for the       |
// |             16-bit data register and its input FIFO.                     |
// | Contents  : DATA_WIDTH, FIFO_DEPTH, FIFO_AF_LEVEL, data_t                |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package register_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int FIFO_DEPTH    = 8;
  localparam int FIFO_AF_LEVEL = 6;

  typedef logic [DATA_WIDTH-1:0] data_t;

endpackage : register_pkg
`default_nettype wire

// File: rtl/reg_input_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : reg_input_fifo_if                                            |
// | Purpose   : Producer / consumer handshake and status bundle of the       |
// |             register input FIFO.                                         |
// | Modports  : master - drives wr_en, wr_data, rd_en; observes status       |
// |             slave  - the FIFO itself                                     |
// | Signals   : wr_en, wr_data, rd_en, data_out, data_valid, full, empty,    |
// |             almost_full, count, overflow, underflow                      |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface reg_input_fifo_if
  import register_pkg::*;
#(
  parameter int DATA_WIDTH = register_pkg::DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
);

  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    data_valid;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  data_out, data_valid, full, empty, almost_full, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output data_out, data_valid, full, empty, almost_full, count,
           overflow, underflow
  );

endinterface : reg_input_fifo_if
`default_nettype wire

// File: rtl/reg_input_fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : reg_fifo_mem                                                 |
// | Purpose   : DEPTH x DATA_WIDTH storage for the register input FIFO.      |
// |             One synchronous write port, one combinational read port.     |
// | Ports     : clk            - clock                                       |
// |             we/waddr/wdata - write port                                  |
// |             raddr/rdata    - asynchronous read port                      |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module reg_fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  wire logic                      clk,
  input  wire logic                      we,
  input  wire logic [$clog2(DEPTH)-1:0]  waddr,
  input  wire logic [DATA_WIDTH-1:0]     wdata,
  input  wire logic [$clog2(DEPTH)-1:0]  raddr,
  output logic      [DATA_WIDTH-1:0]     rdata
);

  // Storage is intentionally not reset: occupancy is tracked by the
  // pointers/count, so stale contents are never observable.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule : reg_fifo_mem
`default_nettype wire

// File: rtl/reg_input_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : reg_input_fifo                                               |
// | Purpose   : Synchronous FIFO upstream of the 16-bit data register. Each  |
// |             accepted pop presents the word on data_out with a one-cycle  |
// |             data_valid strobe (the register's load enable).              |
// | Ports     : clk   - clock, rising edge                                   |
// |             rst_n - synchronous active-low reset                         |
// |             bus   - reg_input_fifo_if.slave (write/read requests, popped |
// |                     data, occupancy and sticky error flags)              |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module reg_input_fifo
  import register_pkg::*;
#(
  parameter int DATA_WIDTH = register_pkg::DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int AF_LEVEL   = FIFO_AF_LEVEL
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  reg_input_fifo_if.slave  bus
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_full  = (r_count == c_CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is still accepted when a pop frees the head slot
  // on the same edge; the pop reads the old head before the write lands.
  assign w_wr_acc = bus.wr_en & (~w_full | bus.rd_en);
  assign w_rd_acc = bus.rd_en & ~w_empty;

  reg_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_acc),
    .waddr (r_wr_ptr),
    .wdata (bus.wr_data),
    .raddr (r_rd_ptr),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_data_valid <= w_rd_acc;

      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end

      if (w_rd_acc) begin
        r_data_out <= w_rdata;
        r_rd_ptr   <= r_rd_ptr + c_PTR_W'(1);
      end

      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (bus.wr_en && w_full && !bus.rd_en) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.data_out    = r_data_out;
  assign bus.data_valid  = r_data_valid;
  assign bus.full        = w_full;
  assign bus.empty       = w_empty;
  assign bus.almost_full = (r_count >= c_CNT_W'(AF_LEVEL));
  assign bus.count       = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;

endmodule : reg_input_fifo
`default_nettype wire

// File: tb/tb_reg_input_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_reg_input_fifo                                            |
// | Purpose   : Self-checking bench for reg_input_fifo: directed table,      |
// |             hand-written corner sequences and randomized traffic against |
// |             a queue-based reference model.                               |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_reg_input_fifo;
  import register_pkg::*;

  localparam int DEPTH = FIFO_DEPTH;
  localparam int AF    = FIFO_AF_LEVEL;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reg_input_fifo_if bus_if ();

  reg_input_fifo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain queue plus flags.
  data_t mq[$];
  data_t m_dout;
  logic  m_valid;
  logic  m_ovf;
  logic  m_udf;

  typedef struct {
    logic  wr;
    logic  rd;
    data_t din;
    int    exp_count;
    data_t exp_dout;
    logic  exp_valid;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, sample 1 ns after the rising edge, advance
  // the model and compare every output against it.
  task automatic step(input logic rst, input logic wr, input logic rd, input data_t d);
    int n;
    @(negedge clk);
    rst_n          = rst;
    bus_if.wr_en   = wr;
    bus_if.rd_en   = rd;
    bus_if.wr_data = d;
    @(posedge clk);
    #1;
    if (!rst) begin
      mq.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      n       = mq.size();
      m_valid = 1'b0;
      if (wr && n == DEPTH && !rd) m_ovf = 1'b1;
      if (rd && n == 0)            m_udf = 1'b1;
      if (rd && n > 0) begin
        m_dout  = mq.pop_front();
        m_valid = 1'b1;
      end
      if (wr && (n < DEPTH || rd)) mq.push_back(d);
    end
    chk("model_data_out",    bus_if.data_out,    m_dout);
    chk("model_data_valid",  bus_if.data_valid,  m_valid);
    chk("model_count",       bus_if.count,       mq.size());
    chk("model_full",        bus_if.full,        mq.size() == DEPTH);
    chk("model_empty",       bus_if.empty,       mq.size() == 0);
    chk("model_almost_full", bus_if.almost_full, mq.size() >= AF);
    chk("model_overflow",    bus_if.overflow,    m_ovf);
    chk("model_underflow",   bus_if.underflow,   m_udf);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic fill(input data_t base, input data_t inc);
    data_t v;
    v = base;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 1'b0, v);
      v = v + inc;
    end
  endtask

  initial begin
    data_t last;
    rst_n          = 1'b0;
    bus_if.wr_en   = 1'b0;
    bus_if.rd_en   = 1'b0;
    bus_if.wr_data = '0;

    // Reset, then idle.
    do_reset();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
    chk("rst_empty",      bus_if.empty,      1'b1);
    chk("rst_count",      bus_if.count,      0);
    chk("rst_data_valid", bus_if.data_valid, 1'b0);
    chk("rst_data_out",   bus_if.data_out,   16'h0000);
    chk("rst_overflow",   bus_if.overflow,   1'b0);
    chk("rst_underflow",  bus_if.underflow,  1'b0);

    // Directed table: 8 writes then 8 reads.
    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{1'b1, 1'b0, data_t'(16'h1111 * (i + 1)), i + 1, 16'h0000, 1'b0};
      tbl[i + 8] = '{1'b0, 1'b1, 16'h0000, 7 - i, data_t'(16'h1111 * (i + 1)), 1'b1};
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk("tbl_count",       bus_if.count,       tbl[i].exp_count);
      chk("tbl_data_out",    bus_if.data_out,    tbl[i].exp_dout);
      chk("tbl_data_valid",  bus_if.data_valid,  tbl[i].exp_valid);
      chk("tbl_full",        bus_if.full,        tbl[i].exp_count == 8);
      chk("tbl_almost_full", bus_if.almost_full, tbl[i].exp_count >= 6);
    end
    chk("tbl_end_empty", bus_if.empty, 1'b1);

    // Overflow on a full FIFO; the dropped word must never surface.
    fill(16'h0100, 16'h0001);
    step(1'b1, 1'b1, 1'b0, 16'hDEAD);
    chk("ovf_flag",  bus_if.overflow, 1'b1);
    chk("ovf_count", bus_if.count,    8);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      chk("ovf_no_dead", bus_if.data_out == 16'hDEAD, 1'b0);
      chk("ovf_drain",   bus_if.data_out, 16'h0100 + i);
    end

    // Full FIFO with simultaneous write and read.
    do_reset();
    fill(16'h1111, 16'h1111);
    step(1'b1, 1'b1, 1'b1, 16'hBEEF);
    chk("fullrw_data_out", bus_if.data_out,   16'h1111);
    chk("fullrw_valid",    bus_if.data_valid, 1'b1);
    chk("fullrw_count",    bus_if.count,      8);
    chk("fullrw_ovf",      bus_if.overflow,   1'b0);
    last = '0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      last = bus_if.data_out;
    end
    chk("fullrw_beef_last", last, 16'hBEEF);

    // Empty FIFO with simultaneous write and read.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 16'hA5A5);
    chk("emptyrw_valid", bus_if.data_valid, 1'b0);
    chk("emptyrw_udf",   bus_if.underflow,  1'b1);
    chk("emptyrw_count", bus_if.count,      1);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("emptyrw_pop",       bus_if.data_out,   16'hA5A5);
    chk("emptyrw_pop_valid", bus_if.data_valid, 1'b1);

    // Reset mid-stream discards stored words.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, data_t'(16'h2000 + i));
    do_reset();
    chk("midrst_count", bus_if.count,     0);
    chk("midrst_empty", bus_if.empty,     1'b1);
    chk("midrst_ovf",   bus_if.overflow,  1'b0);
    chk("midrst_udf",   bus_if.underflow, 1'b0);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("midrst_read_udf",   bus_if.underflow,  1'b1);
    chk("midrst_read_valid", bus_if.data_valid, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) != 0),
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50),
           data_t'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_input_fifo
`default_nettype wire
